jogador_automatico_exp7: RTL



---
 rtl/jogador_automatico_exp7_if.sv | 24 ++
 rtl/jogador_automatico_exp7.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/jogador_automatico_exp7_if.sv
// Signal bundle between the automatic player (master) and the exp7 game side (slave).
interface jogador_automatico_exp7_if;
    logic       iniciar;
    logic       errar;
    logic [3:0] leds;
    logic       ganhou;
    logic       perdeu;
    logic       iniciar_jogo;
    logic [3:0] botoes;
    logic       fim;
    logic [1:0] resultado;
    logic [3:0] db_rodada;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, errar, leds, ganhou, perdeu,
        output iniciar_jogo, botoes, fim, resultado, db_rodada, db_estado
    );

    modport slave (
        output iniciar, errar, leds, ganhou, perdeu,
        input  iniciar_jogo, botoes, fim, resultado, db_rodada, db_estado
    );
endinterface

// File: rtl/jogador_automatico_exp7.sv
// Automatic player for the exp7 memory game: captures the first move, then replays
// the growing sequence and appends one LFSR-chosen move per round until the game ends.
module jogador_automatico_exp7 #(
    parameter int unsigned START_CYCLES = 10,
    parameter int unsigned WAIT_FIRST   = 2000,
    parameter int unsigned PRESS_CYCLES = 10,
    parameter int unsigned GAP_CYCLES   = 10,
    parameter int unsigned RESULT_WAIT  = 100,
    parameter int unsigned ERR_ROUND    = 3,
    parameter logic [4:0]  SEED         = 5'b10011
) (
    input logic clock,
    input logic reset,
    jogador_automatico_exp7_if.master bus
);

    typedef enum logic [3:0] {
        StOcioso         = 4'd0,
        StPulso          = 4'd1,
        StEsperaPrimeira = 4'd2,
        StPressiona      = 4'd3,
        StSolta          = 4'd4,
        StProxima        = 4'd5,
        StEsperaRes      = 4'd6,
        StFimGanhou      = 4'd7,
        StFimPerdeu      = 4'd8,
        StFimErro        = 4'd9
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  rodada_q, rodada_d;
    logic [3:0]  jogada_q, jogada_d;
    logic        errar_q, errar_d;
    logic        captured_q, captured_d;
    logic        inserted_q, inserted_d;
    logic [4:0]  lfsr_q, lfsr_d;
    logic [3:0]  botoes_q, botoes_d;

    logic [3:0]  mem_q [16];
    logic        mem_we;
    logic [3:0]  mem_waddr;
    logic [3:0]  mem_wdata;
    logic [3:0]  first_move;
    logic [3:0]  new_move;

    function automatic logic [3:0] rotl1(input logic [3:0] m);
        return {m[2:0], m[3]};
    endfunction

    always_comb begin
        state_d    = state_q;
        rodada_d   = rodada_q;
        jogada_d   = jogada_q;
        errar_d    = errar_q;
        captured_d = captured_q;
        inserted_d = inserted_q;
        lfsr_d     = lfsr_q;
        botoes_d   = 4'b0000;
        mem_we     = 1'b0;
        mem_waddr  = 4'd0;
        mem_wdata  = 4'd0;
        // Bypass so the first press sees a value captured on the very last wait cycle.
        first_move = (bus.leds != 4'd0) ? bus.leds : mem_q[0];
        new_move   = 4'b0001 << lfsr_q[1:0];

        unique case (state_q)
            StOcioso: begin
                if (bus.iniciar) begin
                    errar_d    = bus.errar;
                    rodada_d   = 4'd0;
                    jogada_d   = 4'd0;
                    captured_d = 1'b0;
                    inserted_d = 1'b0;
                    state_d    = StPulso;
                end
            end
            StPulso: begin
                if (cnt_q == 16'(START_CYCLES - 1)) state_d = StEsperaPrimeira;
            end
            StEsperaPrimeira: begin
                if (bus.leds != 4'd0) begin
                    mem_we     = 1'b1;
                    mem_wdata  = bus.leds;
                    captured_d = 1'b1;
                end
                if (cnt_q == 16'(WAIT_FIRST - 1)) begin
                    if (captured_d) begin
                        rodada_d = 4'd0;
                        jogada_d = 4'd0;
                        state_d  = StPressiona;
                        botoes_d = (errar_q && (ERR_ROUND == 0)) ? rotl1(first_move) : first_move;
                    end else begin
                        state_d = StFimErro;
                    end
                end
            end
            StPressiona: begin
                botoes_d = botoes_q;
                if (cnt_q == 16'(PRESS_CYCLES - 1)) begin
                    botoes_d = 4'b0000;
                    state_d  = StSolta;
                end
            end
            StSolta: begin
                if (cnt_q == 16'(GAP_CYCLES - 1)) state_d = StProxima;
            end
            StProxima: begin
                if (jogada_q < rodada_q) begin
                    jogada_d = jogada_q + 4'd1;
                    botoes_d = mem_q[jogada_d];
                    state_d  = StPressiona;
                end else if (!inserted_q && (rodada_q != 4'd15)) begin
                    inserted_d = 1'b1;
                    mem_we     = 1'b1;
                    mem_waddr  = rodada_q + 4'd1;
                    mem_wdata  = new_move;
                    lfsr_d     = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
                    botoes_d   = new_move;
                    state_d    = StPressiona;
                end else if (inserted_q) begin
                    rodada_d   = rodada_q + 4'd1;
                    jogada_d   = 4'd0;
                    inserted_d = 1'b0;
                    botoes_d   = (errar_q && (rodada_d == 4'(ERR_ROUND))) ? rotl1(mem_q[0])
                                                                           : mem_q[0];
                    state_d    = StPressiona;
                end else begin
                    state_d = StEsperaRes;
                end
            end
            StEsperaRes: begin
                if (cnt_q == 16'(RESULT_WAIT - 1)) state_d = StFimErro;
            end
            StFimGanhou, StFimPerdeu, StFimErro: begin
                if (bus.iniciar) state_d = StOcioso;
            end
            default: state_d = StOcioso;
        endcase

        // Game verdict overrides whatever the play states decided; loss wins ties.
        if (state_q inside {StPressiona, StSolta, StProxima, StEsperaRes}) begin
            if (bus.perdeu || bus.ganhou) begin
                state_d  = bus.perdeu ? StFimPerdeu : StFimGanhou;
                botoes_d = 4'b0000;
                mem_we   = 1'b0;
                lfsr_d   = lfsr_q;
            end
        end
    end

    always_comb begin
        cnt_d = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StOcioso;
            cnt_q      <= 16'd0;
            rodada_q   <= 4'd0;
            jogada_q   <= 4'd0;
            errar_q    <= 1'b0;
            captured_q <= 1'b0;
            inserted_q <= 1'b0;
            lfsr_q     <= SEED;
            botoes_q   <= 4'b0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rodada_q   <= rodada_d;
            jogada_q   <= jogada_d;
            errar_q    <= errar_d;
            captured_q <= captured_d;
            inserted_q <= inserted_d;
            lfsr_q     <= lfsr_d;
            botoes_q   <= botoes_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign bus.botoes       = botoes_q;
    assign bus.iniciar_jogo = (state_q == StPulso);
    assign bus.fim          = state_q inside {StFimGanhou, StFimPerdeu, StFimErro};
    assign bus.resultado    = (state_q == StFimGanhou) ? 2'b01 :
                              (state_q == StFimPerdeu) ? 2'b10 :
                              (state_q == StFimErro)   ? 2'b11 : 2'b00;
    assign bus.db_rodada    = rodada_q;
    assign bus.db_estado    = state_q;

endmodule
